// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded integer register file.
package regfile_pkg;

  localparam int unsigned REGFILE_DATA_W = 32;
  localparam int unsigned REGFILE_DEPTH  = 32;

  typedef logic [4:0]  rf_addr_t;
  typedef logic [31:0] rf_data_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Read, issue and write-back bundle between the pipeline and regfile_sb.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = REGFILE_DATA_W,
  parameter int unsigned DEPTH  = REGFILE_DEPTH,
  parameter int unsigned NUM_RD = 2
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [NUM_RD*AW-1:0]     rs_addr_i;
  logic [NUM_RD*DATA_W-1:0] rs_data_o;
  logic [NUM_RD-1:0]        rs_busy_o;
  logic                     issue_vld_i;
  logic [AW-1:0]            issue_rd_i;
  logic                     wb_vld_i;
  logic [AW-1:0]            wb_addr_i;
  logic [DATA_W-1:0]        wb_data_i;
  logic                     flush_i;
  logic                     wb_err_o;
  logic                     err_clr_i;

  modport master (
    output rs_addr_i, issue_vld_i, issue_rd_i, wb_vld_i, wb_addr_i, wb_data_i,
           flush_i, err_clr_i,
    input  rs_data_o, rs_busy_o, wb_err_o
  );

  modport slave (
    input  rs_addr_i, issue_vld_i, issue_rd_i, wb_vld_i, wb_addr_i, wb_data_i,
           flush_i, err_clr_i,
    output rs_data_o, rs_busy_o, wb_err_o
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write busy bits per register plus the sticky write-back error flag.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned DEPTH = REGFILE_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_issue_vld,
  input  logic [AW-1:0]    i_issue_rd,
  input  logic             i_wb_vld,
  input  logic [AW-1:0]    i_wb_addr,
  input  logic             i_flush,
  input  logic             i_err_clr,
  output logic [DEPTH-1:0] o_busy,
  output logic             o_wb_err
);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;
  logic             r_err;
  logic             w_err_set;

  // Priority low to high: flush, write-back clear, issue set (new producer wins)
  always_comb begin
    w_busy_nxt = i_flush ? '0 : r_busy;
    if (i_wb_vld)    w_busy_nxt[i_wb_addr]  = 1'b0;
    if (i_issue_vld) w_busy_nxt[i_issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  assign w_err_set = i_wb_vld && (i_wb_addr != '0) && !r_busy[i_wb_addr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_err  <= w_err_set || (r_err && !i_err_clr);
    end
  end

  assign o_busy   = r_busy;
  assign o_wb_err = r_err;

endmodule

// File: rtl/regfile_sb.sv
// Register file with NUM_RD combinational read ports, one write-back port and a scoreboard.
// Define REGFILE_SB_BYPASS_EN to forward write-back data to matching read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = REGFILE_DATA_W,
  parameter int unsigned DEPTH  = REGFILE_DEPTH,
  parameter int unsigned NUM_RD = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  regfile_sb_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0]        r_mem [DEPTH];
  logic [DEPTH-1:0]         w_busy;
  logic [AW-1:0]            w_addr [NUM_RD];
  logic                     w_hit  [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] w_rd_data;
  logic [NUM_RD-1:0]        w_rd_busy;

  regfile_scoreboard #(.DEPTH(DEPTH)) u_sb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_issue_vld (bus.issue_vld_i),
    .i_issue_rd  (bus.issue_rd_i),
    .i_wb_vld    (bus.wb_vld_i),
    .i_wb_addr   (bus.wb_addr_i),
    .i_flush     (bus.flush_i),
    .i_err_clr   (bus.err_clr_i),
    .o_busy      (w_busy),
    .o_wb_err    (bus.wb_err_o)
  );

  // x0 is never written, so it stays at its reset value of zero
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (bus.wb_vld_i && (bus.wb_addr_i != '0)) begin
      r_mem[bus.wb_addr_i] <= bus.wb_data_i;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    assign w_addr[k] = bus.rs_addr_i[k*AW +: AW];
`ifdef REGFILE_SB_BYPASS_EN
    assign w_hit[k] = bus.wb_vld_i && (bus.wb_addr_i == w_addr[k]) && (w_addr[k] != '0);
`else
    assign w_hit[k] = 1'b0;
`endif
  end

  // Forwarded data reports not-busy: the value being returned is the final one
  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      if (w_hit[k]) begin
        w_rd_data[k*DATA_W +: DATA_W] = bus.wb_data_i;
      end else if (w_addr[k] != '0) begin
        w_rd_data[k*DATA_W +: DATA_W] = r_mem[w_addr[k]];
        w_rd_busy[k]                  = w_busy[w_addr[k]];
      end
    end
  end

  assign bus.rs_data_o = w_rd_data;
  assign bus.rs_busy_o = w_rd_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a default 32x32/2-port instance and a 64-bit 16-deep 3-port instance.
module tb_regfile_sb;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  regfile_sb_if #(.DATA_W(32), .DEPTH(32), .NUM_RD(2)) if_a ();
  regfile_sb_if #(.DATA_W(64), .DEPTH(16), .NUM_RD(3)) if_w ();

  regfile_sb #(.DATA_W(32), .DEPTH(32), .NUM_RD(2)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(if_a)
  );
  regfile_sb #(.DATA_W(64), .DEPTH(16), .NUM_RD(3)) u_dut_w (
    .clk_i(clk_i), .rst_i(rst_i), .bus(if_w)
  );

  // Stimulus per instance (0 = default, 1 = wide)
  int          t_addr      [2][3];
  logic        t_issue_vld [2];
  int          t_issue_rd  [2];
  logic        t_wb_vld    [2];
  int          t_wb_addr   [2];
  logic [63:0] t_wb_data   [2];
  logic        t_flush     [2];
  logic        t_err_clr   [2];

  // Reference state: architectural register values, pending writes, error flag
  logic [63:0] m_mem  [2][32];
  logic        m_busy [2][32];
  logic        m_err  [2];

  int n_chk  = 0;
  int n_pass = 0;

  assign if_a.rs_addr_i   = {5'(t_addr[0][1]), 5'(t_addr[0][0])};
  assign if_a.issue_vld_i = t_issue_vld[0];
  assign if_a.issue_rd_i  = 5'(t_issue_rd[0]);
  assign if_a.wb_vld_i    = t_wb_vld[0];
  assign if_a.wb_addr_i   = 5'(t_wb_addr[0]);
  assign if_a.wb_data_i   = t_wb_data[0][31:0];
  assign if_a.flush_i     = t_flush[0];
  assign if_a.err_clr_i   = t_err_clr[0];

  assign if_w.rs_addr_i   = {4'(t_addr[1][2]), 4'(t_addr[1][1]), 4'(t_addr[1][0])};
  assign if_w.issue_vld_i = t_issue_vld[1];
  assign if_w.issue_rd_i  = 4'(t_issue_rd[1]);
  assign if_w.wb_vld_i    = t_wb_vld[1];
  assign if_w.wb_addr_i   = 4'(t_wb_addr[1]);
  assign if_w.wb_data_i   = t_wb_data[1];
  assign if_w.flush_i     = t_flush[1];
  assign if_w.err_clr_i   = t_err_clr[1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int dep(input int i);
    return (i == 0) ? 32 : 16;
  endfunction

  function automatic int nrd(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  function automatic logic [63:0] rd_data(input int i, input int k);
    if (i == 0) return 64'(if_a.rs_data_o[k*32 +: 32]);
    return if_w.rs_data_o[k*64 +: 64];
  endfunction

  function automatic logic rd_busy(input int i, input int k);
    if (i == 0) return if_a.rs_busy_o[k];
    return if_w.rs_busy_o[k];
  endfunction

  function automatic logic get_err(input int i);
    return (i == 0) ? if_a.wb_err_o : if_w.wb_err_o;
  endfunction

  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 3; k++) t_addr[i][k] = 0;
      t_issue_vld[i] = 1'b0; t_issue_rd[i] = 0;
      t_wb_vld[i]    = 1'b0; t_wb_addr[i]  = 0; t_wb_data[i] = '0;
      t_flush[i]     = 1'b0; t_err_clr[i]  = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 32; a++) begin
        m_mem[i][a]  = '0;
        m_busy[i][a] = 1'b0;
      end
      m_err[i] = 1'b0;
    end
  endtask

  // Compare every read port, busy bit and error flag against the reference
  task automatic check_model();
    logic [63:0] ed;
    logic        eb;
    int          a;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < nrd(i); k++) begin
        a  = t_addr[i][k];
        ed = '0;
        eb = 1'b0;
        if (a != 0) begin
          ed = m_mem[i][a];
          eb = m_busy[i][a];
`ifdef REGFILE_SB_BYPASS_EN
          if (t_wb_vld[i] && t_wb_addr[i] == a) begin
            ed = t_wb_data[i];
            eb = 1'b0;
          end
`endif
        end
        check($sformatf("data_i%0d_p%0d_x%0d", i, k, a), rd_data(i, k), ed);
        check($sformatf("busy_i%0d_p%0d_x%0d", i, k, a), 64'(rd_busy(i, k)), 64'(eb));
      end
      check($sformatf("err_i%0d", i), 64'(get_err(i)), 64'(m_err[i]));
    end
  endtask

  // Apply the clock-edge rules to the reference state of instance i
  task automatic model_edge(input int i);
    logic nb [32];
    logic wv;
    int   wa;
    wa = t_wb_addr[i];
    wv = t_wb_vld[i] && (wa != 0);
    if (wv && !m_busy[i][wa]) m_err[i] = 1'b1;
    else if (t_err_clr[i])    m_err[i] = 1'b0;
    for (int a = 0; a < 32; a++) begin
      if (a != 0 && t_issue_vld[i] && t_issue_rd[i] == a) nb[a] = 1'b1;
      else if (t_flush[i] || (wv && wa == a))             nb[a] = 1'b0;
      else                                                nb[a] = m_busy[i][a];
    end
    for (int a = 0; a < 32; a++) m_busy[i][a] = nb[a];
    if (wv) m_mem[i][wa] = t_wb_data[i];
  endtask

  task automatic settle();
    @(negedge clk_i);
    check_model();
  endtask

  task automatic commit();
    @(posedge clk_i);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic cycle();
    settle();
    commit();
  endtask

  initial begin
    idle();
    model_reset();
    rst_i = 1'b1;
    #1;
    check_model();
    check("rst_err", 64'(if_a.wb_err_o), 64'h0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Write x5, read back on both ports the next cycle
    idle(); t_wb_vld[0] = 1'b1; t_wb_addr[0] = 5; t_wb_data[0] = 64'hDEADBEEF;
    cycle();
    idle(); t_addr[0][0] = 5; t_addr[0][1] = 5; t_err_clr[0] = 1'b1;
    settle();
    check("x5_p0", rd_data(0, 0), 64'hDEADBEEF);
    check("x5_p1", rd_data(0, 1), 64'hDEADBEEF);
    commit();

    // Write to x0 is dropped
    idle(); t_wb_vld[0] = 1'b1; t_wb_addr[0] = 0; t_wb_data[0] = 64'h1234;
    cycle();
    idle();
    settle();
    check("x0_read", rd_data(0, 0), 64'h0);
    check("x0_no_err", 64'(get_err(0)), 64'h0);
    commit();

    // Issue x7, then write it back
    idle(); t_issue_vld[0] = 1'b1; t_issue_rd[0] = 7;
    cycle();
    idle(); t_addr[0][0] = 7;
    settle();
    check("x7_busy_after_issue", 64'(rd_busy(0, 0)), 64'h1);
    commit();
    idle(); t_wb_vld[0] = 1'b1; t_wb_addr[0] = 7; t_wb_data[0] = 64'h77;
    cycle();
    idle(); t_addr[0][0] = 7;
    settle();
    check("x7_busy_after_wb", 64'(rd_busy(0, 0)), 64'h0);
    check("x7_wb_no_err", 64'(get_err(0)), 64'h0);
    commit();

    // Issue and write-back of x7 on the same edge: new producer keeps it busy
    idle(); t_issue_vld[0] = 1'b1; t_issue_rd[0] = 7;
    cycle();
    idle(); t_issue_vld[0] = 1'b1; t_issue_rd[0] = 7;
    t_wb_vld[0] = 1'b1; t_wb_addr[0] = 7; t_wb_data[0] = 64'h78;
    cycle();
    idle(); t_addr[0][0] = 7;
    settle();
    check("x7_busy_same_cycle", 64'(rd_busy(0, 0)), 64'h1);
    check("x7_same_cycle_no_err", 64'(get_err(0)), 64'h0);
    commit();

    // Flush with x3 and x9 busy
    idle(); t_issue_vld[0] = 1'b1; t_issue_rd[0] = 3;
    cycle();
    idle(); t_issue_vld[0] = 1'b1; t_issue_rd[0] = 9;
    cycle();
    idle(); t_addr[0][0] = 3; t_addr[0][1] = 9; t_flush[0] = 1'b1;
    settle();
    check("x3_busy_pre_flush", 64'(rd_busy(0, 0)), 64'h1);
    check("x9_busy_pre_flush", 64'(rd_busy(0, 1)), 64'h1);
    commit();
    idle(); t_addr[0][0] = 3; t_addr[0][1] = 9;
    settle();
    check("x3_busy_post_flush", 64'(rd_busy(0, 0)), 64'h0);
    check("x9_busy_post_flush", 64'(rd_busy(0, 1)), 64'h0);
    commit();

    // Flush and issue on the same edge: the issue survives
    idle(); t_flush[0] = 1'b1; t_issue_vld[0] = 1'b1; t_issue_rd[0] = 12;
    cycle();
    idle(); t_addr[0][0] = 12;
    settle();
    check("x12_issue_beats_flush", 64'(rd_busy(0, 0)), 64'h1);
    commit();

    // Write-back to a non-busy x4 flags an error but still writes
    idle(); t_wb_vld[0] = 1'b1; t_wb_addr[0] = 4; t_wb_data[0] = 64'h44;
    cycle();
    idle(); t_addr[0][0] = 4; t_err_clr[0] = 1'b1;
    settle();
    check("x4_err_set", 64'(get_err(0)), 64'h1);
    check("x4_written", rd_data(0, 0), 64'h44);
    commit();
    idle();
    settle();
    check("err_cleared", 64'(get_err(0)), 64'h0);
    commit();

    // Clear and new error on the same edge: flag stays set
    idle(); t_err_clr[0] = 1'b1; t_wb_vld[0] = 1'b1; t_wb_addr[0] = 6; t_wb_data[0] = 64'h66;
    cycle();
    idle(); t_err_clr[0] = 1'b1;
    settle();
    check("err_new_beats_clr", 64'(get_err(0)), 64'h1);
    commit();

    // Read x10 in the cycle it is written
    idle(); t_addr[0][0] = 10; t_wb_vld[0] = 1'b1; t_wb_addr[0] = 10; t_wb_data[0] = 64'hCAFEF00D;
    settle();
`ifdef REGFILE_SB_BYPASS_EN
    check("x10_bypass_data", rd_data(0, 0), 64'hCAFEF00D);
`else
    check("x10_old_data", rd_data(0, 0), 64'h0);
`endif
    check("x10_same_cycle_busy", 64'(rd_busy(0, 0)), 64'h0);
    commit();
    idle(); t_addr[0][0] = 10;
    settle();
    check("x10_next_cycle", rd_data(0, 0), 64'hCAFEF00D);
    commit();

    // Wide instance: x15 back on all three ports, neighbours on distinct ports
    idle(); t_wb_vld[1] = 1'b1; t_wb_addr[1] = 15; t_wb_data[1] = 64'hFFFF_FFFF_0000_0001;
    cycle();
    idle(); t_wb_vld[1] = 1'b1; t_wb_addr[1] = 14; t_wb_data[1] = 64'h0123_4567_89AB_CDEF;
    t_addr[1][0] = 15; t_addr[1][1] = 15; t_addr[1][2] = 15;
    settle();
    for (int k = 0; k < 3; k++)
      check($sformatf("w_x15_p%0d", k), rd_data(1, k), 64'hFFFF_FFFF_0000_0001);
    commit();
    idle(); t_addr[1][0] = 0; t_addr[1][1] = 14; t_addr[1][2] = 15;
    settle();
    check("w_p0_x0",  rd_data(1, 0), 64'h0);
    check("w_p1_x14", rd_data(1, 1), 64'h0123_4567_89AB_CDEF);
    check("w_p2_x15", rd_data(1, 2), 64'hFFFF_FFFF_0000_0001);
    commit();

    // Async reset in mid-cycle clears outputs without a clock edge
    idle(); t_addr[0][0] = 5; t_addr[0][1] = 10;
    t_addr[1][0] = 15; t_addr[1][1] = 14; t_addr[1][2] = 15;
    #2;
    rst_i = 1'b1;
    #1;
    model_reset();
    check_model();
    check("rst_mid_x5", rd_data(0, 0), 64'h0);
    check("rst_mid_w_x15", rd_data(1, 0), 64'h0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Randomized traffic on both instances
    for (int n = 0; n < 400; n++) begin
      idle();
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < nrd(i); k++) t_addr[i][k] = int'($urandom_range(0, dep(i) - 1));
        t_issue_vld[i] = 1'($urandom_range(0, 1));
        t_issue_rd[i]  = int'($urandom_range(0, dep(i) - 1));
        t_wb_vld[i]    = 1'($urandom_range(0, 1));
        t_wb_addr[i]   = int'($urandom_range(0, dep(i) - 1));
        t_wb_data[i]   = {32'($urandom), 32'($urandom)};
        if (i == 0) t_wb_data[i][63:32] = '0;
        t_flush[i]     = ($urandom_range(0, 19) == 0);
        t_err_clr[i]   = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 3) == 0) t_addr[i][0] = t_wb_addr[i];
      end
      cycle();
    end

    idle();
    settle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
